// File: rtl/decode_stage_pipe.sv
// Pipelined instruction-decode stage: register file with write-to-read bypass,
// immediate extension, destination select and a handshaked ID/EX register.
module decode_stage_pipe #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic              reg_dst,
    input  logic              jal,
    input  logic              wb_we,
    input  logic              wb_link,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [ADDR_W-1:0] out_dest,
    output logic [ADDR_W-1:0] out_rs,
    output logic [ADDR_W-1:0] out_rt,
    output logic [DATA_W-1:0] out_pc4,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned       NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    typedef enum logic [5:0] {
        OP_JAL   = 6'h03,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F
    } opcode_e;

    logic [DATA_W-1:0] rf [NREGS];

    logic              wr_fire;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [5:0]        opcode;
    logic [15:0]       imm16;
    logic [ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [DATA_W-1:0] imm_val;
    logic [ADDR_W-1:0] dest_val;

    logic              xfer;
    logic              load;
    logic              stalled;

    // Effective write-back address/data and fire condition (r0 is never written)
    always_comb begin
        wr_addr = wb_link ? LINK_IDX : wb_addr;
        wr_data = wb_link ? wb_pc4 : wb_data;
        wr_fire = (wb_we || wb_link) && (wr_addr != '0);
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_fire) begin
            rf[wr_addr] <= wr_data;
        end
    end

    // Field extraction and bypassed combinational register reads
    always_comb begin
        opcode = instruction[31:26];
        imm16  = instruction[15:0];
        rs_idx = ADDR_W'(instruction[25:21]);
        rt_idx = ADDR_W'(instruction[20:16]);
        rd_idx = ADDR_W'(instruction[15:11]);

        rs_val = '0;
        if (rs_idx != '0) begin
            rs_val = (wr_fire && wr_addr == rs_idx) ? wr_data : rf[rs_idx];
        end
        rt_val = '0;
        if (rt_idx != '0) begin
            rt_val = (wr_fire && wr_addr == rt_idx) ? wr_data : rf[rt_idx];
        end
    end

    // Immediate extension and destination register selection
    always_comb begin
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: imm_val = DATA_W'(imm16);
            OP_LUI:  imm_val = DATA_W'(signed'({imm16, 16'h0000}));
            default: imm_val = DATA_W'(signed'(imm16));
        endcase

        if (jal && opcode == OP_JAL) begin
            dest_val = LINK_IDX;
        end else begin
            dest_val = reg_dst ? rd_idx : rt_idx;
        end
    end

    // Handshake decode
    always_comb begin
        in_ready = !out_valid || out_ready;
        xfer     = in_valid && in_ready;
        load     = xfer && !flush;
        stalled  = in_valid && !in_ready;
    end

    // ID/EX valid flag: flush beats capture; a drained slot with no new input empties
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ID/EX payload; while not loading, held operands track writes to their index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_imm     <= '0;
            out_dest    <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_pc4     <= '0;
        end else if (load) begin
            out_rs_data <= rs_val;
            out_rt_data <= rt_val;
            out_imm     <= imm_val;
            out_dest    <= dest_val;
            out_rs      <= rs_idx;
            out_rt      <= rt_idx;
            out_pc4     <= in_pc4;
        end else begin
            if (wr_fire && wr_addr == out_rs) begin
                out_rs_data <= wr_data;
            end
            if (wr_fire && wr_addr == out_rt) begin
                out_rt_data <= wr_data;
            end
        end
    end

    // Saturating count of cycles where input is offered but refused
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stalled && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe.
module tb_decode_stage_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] in_pc4;
    logic        reg_dst;
    logic        jal;
    logic        wb_we;
    logic        wb_link;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs_data;
    logic [31:0] out_rt_data;
    logic [31:0] out_imm;
    logic [4:0]  out_dest;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [31:0] out_pc4;
    logic [2:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    decode_stage_pipe #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .LINK_REG(31),
        .CNT_W   (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruction(instruction),
        .in_pc4     (in_pc4),
        .reg_dst    (reg_dst),
        .jal        (jal),
        .wb_we      (wb_we),
        .wb_link    (wb_link),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_pc4     (wb_pc4),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rs_data(out_rs_data),
        .out_rt_data(out_rt_data),
        .out_imm    (out_imm),
        .out_dest   (out_dest),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_pc4    (out_pc4),
        .stall_cnt  (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        reset = 1'b1; in_valid = 0; instruction = '0; in_pc4 = '0; reg_dst = 0; jal = 0;
        wb_we = 0; wb_link = 0; wb_addr = '0; wb_data = '0; wb_pc4 = '0; flush = 0; out_ready = 1;
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        chk("rst_rs_data", out_rs_data, 32'd0);
        reset = 1'b0;

        // 1: write r5, then decode add r3,r5,r0
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'h1234;
        step();
        wb_we = 0;
        in_valid = 1; reg_dst = 1; instruction = rtype(5'd5, 5'd0, 5'd3); in_pc4 = 32'h100;
        step();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_rs_data", out_rs_data, 32'h1234);
        chk("t1_rt_data", out_rt_data, 32'h0);
        chk("t1_dest", {27'd0, out_dest}, 32'd3);
        chk("t1_rs_idx", {27'd0, out_rs}, 32'd5);
        chk("t1_pc4", out_pc4, 32'h100);
        in_valid = 0;
        step();
        chk("t1_drain", {31'd0, out_valid}, 32'd0);

        // 2: bypass on r7, write to r0 ignored, stored r7 later
        in_valid = 1; instruction = rtype(5'd7, 5'd5, 5'd4);
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'hCAFE;
        step();
        chk("t2_bypass_rs", out_rs_data, 32'hCAFE);
        chk("t2_rt_r5", out_rt_data, 32'h1234);
        instruction = rtype(5'd0, 5'd0, 5'd1); wb_addr = 5'd0; wb_data = 32'hDEAD;
        step();
        chk("t2_r0_rs", out_rs_data, 32'h0);
        chk("t2_r0_rt", out_rt_data, 32'h0);
        wb_we = 0; instruction = rtype(5'd7, 5'd0, 5'd8);
        step();
        chk("t2_r7_stored", out_rs_data, 32'hCAFE);

        // 3: immediates
        reg_dst = 0;
        instruction = itype(6'h0D, 5'd0, 5'd2, 16'h8001);
        step();
        chk("t3_ori_imm", out_imm, 32'h0000_8001);
        chk("t3_ori_dest", {27'd0, out_dest}, 32'd2);
        instruction = itype(6'h08, 5'd0, 5'd2, 16'h8001);
        step();
        chk("t3_addi_imm", out_imm, 32'hFFFF_8001);
        instruction = itype(6'h0F, 5'd0, 5'd2, 16'h8001);
        step();
        chk("t3_lui_imm", out_imm, 32'h8001_0000);
        instruction = itype(6'h0B, 5'd0, 5'd2, 16'hFFFF);
        step();
        chk("t3_sltiu_imm", out_imm, 32'h0000_FFFF);

        // 4: jal decode with simultaneous link write
        jal = 1; instruction = {6'h03, 26'h0000100}; in_pc4 = 32'h400;
        wb_link = 1; wb_addr = 5'd9; wb_data = 32'hBAD; wb_pc4 = 32'h404;
        step();
        chk("t4_jal_dest", {27'd0, out_dest}, 32'd31);
        chk("t4_jal_pc4", out_pc4, 32'h400);
        wb_link = 0; reg_dst = 1; instruction = rtype(5'd31, 5'd9, 5'd2);
        step();
        chk("t4_r31_link", out_rs_data, 32'h404);
        chk("t4_r9_untouched", out_rt_data, 32'h0);
        chk("t4_jal_nonjal_op", {27'd0, out_dest}, 32'd2);
        jal = 0;

        // 5: stall with held operand update
        instruction = rtype(5'd5, 5'd7, 5'd6); in_pc4 = 32'h500;
        step();
        chk("t5_load_rs", out_rs_data, 32'h1234);
        out_ready = 0; instruction = rtype(5'd10, 5'd5, 5'd11); in_pc4 = 32'h600;
        #1;
        chk("t5_in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        chk("t5_cnt1", {29'd0, stall_cnt}, 32'd1);
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'h5555;
        step();
        chk("t5_held_rs_upd", out_rs_data, 32'h5555);
        chk("t5_held_dest", {27'd0, out_dest}, 32'd6);
        wb_we = 0;
        step();
        chk("t5_cnt3", {29'd0, stall_cnt}, 32'd3);
        chk("t5_held_rt", out_rt_data, 32'hCAFE);
        chk("t5_held_pc4", out_pc4, 32'h500);
        chk("t5_held_valid", {31'd0, out_valid}, 32'd1);

        // 6: flush discards the transfer but keeps the write
        out_ready = 1; flush = 1; wb_we = 1; wb_addr = 5'd10; wb_data = 32'hA0A0;
        step();
        chk("t6_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_flush_cnt", {29'd0, stall_cnt}, 32'd3);
        flush = 0; wb_we = 0;
        step();
        chk("t6_after_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_r10_written", out_rs_data, 32'hA0A0);
        chk("t6_r5_held_write", out_rt_data, 32'h5555);
        chk("t6_pc4", out_pc4, 32'h600);

        // saturation, then asynchronous reset mid-stall
        out_ready = 0;
        step(); step(); step(); step();
        chk("t6_sat7", {29'd0, stall_cnt}, 32'd7);
        step(); step();
        chk("t6_sat_hold", {29'd0, stall_cnt}, 32'd7);
        #2 reset = 1;
        #1;
        chk("t6_arst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_arst_cnt", {29'd0, stall_cnt}, 32'd0);
        chk("t6_arst_rs_data", out_rs_data, 32'd0);
        chk("t6_arst_dest", {27'd0, out_dest}, 32'd0);
        chk("t6_arst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 0; out_ready = 1; instruction = rtype(5'd5, 5'd10, 5'd1);
        step();
        chk("t6_rf_clr_r5", out_rs_data, 32'd0);
        chk("t6_rf_clr_r10", out_rt_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
